// File: rtl/multdiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the execute
// stage that drives it.
package multdiv_pkg;

  localparam int MULTDIV_WIDTH = 32;

  // ALU op codes the execute stage decodes into ctrl_MULT / ctrl_DIV
  localparam logic [4:0] ALU_OP_MUL = 5'b00110;
  localparam logic [4:0] ALU_OP_DIV = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_e;

  // Radix-2 Booth recoding of {current multiplier bit, previous bit}
  function automatic booth_e booth_decode(input logic [1:0] pair);
    booth_e act;
    case (pair)
      2'b01:   act = BOOTH_ADD;
      2'b10:   act = BOOTH_SUB;
      default: act = BOOTH_NOP;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/multdiv_seq_if.sv
// Operand/start/result bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface multdiv_seq_if
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MULTDIV_WIDTH
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_seq_div_restore_step.sv
// One restoring-division step: subtract the divisor from the shifted partial
// remainder when it fits, producing one quotient bit.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic             fits_s;
  logic [WIDTH-1:0] diff_s;

  assign fits_s = (rem_in >= {1'b0, divisor});
  // The true difference is below the divisor, so modulo-2^WIDTH is exact
  assign diff_s = rem_in[WIDTH-1:0] - divisor;

  // Restore (keep) the remainder when the divisor does not fit
  always_comb begin
    q_bit   = 1'b0;
    rem_out = rem_in[WIDTH-1:0];
    if (fits_s) begin
      q_bit   = 1'b1;
      rem_out = diff_s;
    end else begin
      q_bit   = 1'b0;
      rem_out = rem_in[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit with a
// fixed WIDTH+1 cycle latency from start to the ready strobe.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MULTDIV_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  multdiv_seq_if.slave bus
);
  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam int               PW        = 2 * WIDTH + 1;

  state_e           state_r, state_s;
  op_e              op_r, op_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             sign_a_r, sign_a_s;
  logic             sign_b_r, sign_b_s;
  logic [WIDTH-1:0] opb_r, opb_s;
  logic [PW-1:0]    prod_r, prod_s;
  logic [WIDTH-1:0] quo_r, quo_s;
  logic [WIDTH-1:0] rem_r, rem_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             exc_r, exc_s;
  logic             rdy_r, rdy_s;

  logic             start_s;
  logic [WIDTH:0]   acc_ext_s;
  logic [WIDTH:0]   mcand_ext_s;
  logic [WIDTH:0]   booth_sum_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_q_s;
  logic [WIDTH-1:0] quo_signed_s;
  logic             mul_ovf_s;
  logic             div_ovf_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  assign start_s = bus.ctrl_MULT | bus.ctrl_DIV;

  // Accumulator is widened by one bit so subtracting the most negative
  // multiplicand cannot wrap before the arithmetic shift.
  assign acc_ext_s   = {prod_r[PW-1], prod_r[PW-1:WIDTH+1]};
  assign mcand_ext_s = {opb_r[WIDTH-1], opb_r};

  // Booth add/subtract of the multiplicand into the accumulator
  always_comb begin
    booth_sum_s = acc_ext_s;
    case (booth_decode(prod_r[1:0]))
      BOOTH_ADD: booth_sum_s = acc_ext_s + mcand_ext_s;
      BOOTH_SUB: booth_sum_s = acc_ext_s - mcand_ext_s;
      BOOTH_NOP: booth_sum_s = acc_ext_s;
      default:   booth_sum_s = acc_ext_s;
    endcase
  end

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  ({rem_r, quo_r[WIDTH-1]}),
    .divisor (opb_r),
    .rem_out (step_rem_s),
    .q_bit   (step_q_s)
  );

  assign quo_signed_s = (sign_a_r ^ sign_b_r) ? (~quo_r + WIDTH'(1)) : quo_r;
  assign mul_ovf_s    = (prod_r[PW-1:WIDTH] != {(WIDTH+1){prod_r[WIDTH]}});
  // A full-scale magnitude quotient is only representable when negated
  assign div_ovf_s    = quo_r[WIDTH-1] & ~(sign_a_r ^ sign_b_r);

  // Next-state and datapath update; a start in any state restarts the unit
  always_comb begin
    state_s  = state_r;
    op_s     = op_r;
    count_s  = count_r;
    sign_a_s = sign_a_r;
    sign_b_s = sign_b_r;
    opb_s    = opb_r;
    prod_s   = prod_r;
    quo_s    = quo_r;
    rem_s    = rem_r;
    result_s = result_r;
    exc_s    = exc_r;
    rdy_s    = 1'b0;

    if (start_s) begin
      state_s  = RUN;
      op_s     = bus.ctrl_MULT ? OP_MUL : OP_DIV;
      count_s  = {CNT_W{1'b0}};
      sign_a_s = bus.data_operandA[WIDTH-1];
      sign_b_s = bus.data_operandB[WIDTH-1];
      opb_s    = bus.ctrl_MULT ? bus.data_operandB : magnitude(bus.data_operandB);
      prod_s   = {{WIDTH{1'b0}}, bus.data_operandA, 1'b0};
      quo_s    = magnitude(bus.data_operandA);
      rem_s    = {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        RUN: begin
          if (op_r == OP_MUL) begin
            prod_s = {booth_sum_s, prod_r[WIDTH:1]};
          end else begin
            rem_s = step_rem_s;
            quo_s = {quo_r[WIDTH-2:0], step_q_s};
          end
          count_s = count_r + CNT_W'(1);
          if (count_r == LAST_ITER) begin
            state_s = FIX;
          end else begin
            state_s = RUN;
          end
        end
        FIX: begin
          state_s = IDLE;
          rdy_s   = 1'b1;
          if (op_r == OP_MUL) begin
            result_s = prod_r[WIDTH:1];
            exc_s    = mul_ovf_s;
          end else if (opb_r == {WIDTH{1'b0}}) begin
            result_s = {WIDTH{1'b0}};
            exc_s    = 1'b1;
          end else begin
            result_s = quo_signed_s;
            exc_s    = div_ovf_s;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      op_r     <= OP_MUL;
      count_r  <= {CNT_W{1'b0}};
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      opb_r    <= {WIDTH{1'b0}};
      prod_r   <= {PW{1'b0}};
      quo_r    <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      exc_r    <= 1'b0;
      rdy_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      op_r     <= op_s;
      count_r  <= count_s;
      sign_a_r <= sign_a_s;
      sign_b_r <= sign_b_s;
      opb_r    <= opb_s;
      prod_r   <= prod_s;
      quo_r    <= quo_s;
      rem_r    <= rem_s;
      result_r <= result_s;
      exc_r    <= exc_s;
      rdy_r    <= rdy_s;
    end
  end

  assign bus.data_result    = result_r;
  assign bus.data_exception = exc_r;
  assign bus.data_resultRDY = rdy_r;
endmodule

// File: tb/tb_multdiv_seq.sv
// Directed and randomized checks of multdiv_seq against an arithmetic
// reference model (native signed multiply/divide).
module tb_multdiv_seq;
  localparam int W = 32;

  logic clock;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  multdiv_seq_if #(.WIDTH(W)) bus ();

  multdiv_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [31:0] r;
    logic        e;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
    e = (p != longint'($signed(r)));
    return {e, r};
  endfunction

  function automatic logic [32:0] div_model(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) return {1'b1, 32'h0000_0000};
    if (sa == int'(32'h8000_0000) && sb == -1) return {1'b1, 32'h8000_0000};
    return {1'b0, 32'(sa / sb)};
  endfunction

  // Start at E0, then watch edges E1..E36 for the strobe and the results
  task automatic run_op(input string tag, input logic mul, input logic div,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc);
    int          first;
    int          hits;
    logic [31:0] got_res;
    logic        got_exc;
    first   = 0;
    hits    = 0;
    got_res = 32'h0;
    got_exc = 1'b0;
    @(negedge clock);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = mul;
    bus.ctrl_DIV      = div;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) begin
        hits++;
        if (first == 0) begin
          first   = k;
          got_res = bus.data_result;
          got_exc = bus.data_exception;
        end
      end
    end
    check({tag, " strobe_edge"}, 64'(first), 64'd33);
    check({tag, " strobe_count"}, 64'(hits), 64'd1);
    check({tag, " result"}, 64'(got_res), 64'(exp_res));
    check({tag, " exception"}, 64'(got_exc), 64'(exp_exc));
    check({tag, " result_hold"}, 64'(bus.data_result), 64'(exp_res));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] ref_v;
    logic        is_mul;
    logic        both;
    int          shape;
    int          ta;
    int          tb2;
    int          first;
    int          hits;

    bus.data_operandA = 32'h0;
    bus.data_operandB = 32'h0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    reset             = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset result", 64'(bus.data_result), 64'd0);
    check("reset exception", 64'(bus.data_exception), 64'd0);
    check("reset ready", 64'(bus.data_resultRDY), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Directed cases with hand-derived expectations
    run_op("mul 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("mul 2^16*2^16", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run_op("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("div 100/-7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
    run_op("div 5/0", 1'b0, 1'b1, 32'd5, 32'd0, 32'h0000_0000, 1'b1);
    run_op("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("div min/1", 1'b0, 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    run_op("mul min*min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
    run_op("both high mul wins", 1'b1, 1'b1, 32'd9, 32'd3, 32'd27, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      is_mul = 1'($urandom_range(0, 1));
      shape  = int'($urandom_range(0, 3));
      a      = $urandom;
      b      = $urandom;
      if (shape == 0) begin
        ta  = int'($urandom_range(0, 2000)) - 1000;
        tb2 = int'($urandom_range(0, 2000)) - 1000;
        a   = ta;
        b   = tb2;
      end else if (shape == 1) begin
        a = {{16{a[15]}}, a[15:0]};
        b = {{16{b[15]}}, b[15:0]};
      end else if (shape == 2) begin
        b = is_mul ? 32'h8000_0000 : 32'h0000_0000;
      end else begin
        tb2 = int'($urandom_range(1, 9));
        b   = b[0] ? 32'(-tb2) : 32'(tb2);
      end
      both  = is_mul & 1'($urandom_range(0, 1));
      ref_v = is_mul ? mul_model(a, b) : div_model(a, b);
      run_op($sformatf("rand%0d", i), is_mul, (~is_mul) | both, a, b, ref_v[31:0], ref_v[32]);
    end

    // Abort: multiply started at E0, divide 100/7 restarts at E10
    @(negedge clock);
    bus.data_operandA = 32'd3;
    bus.data_operandB = 32'd4;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    first = 0;
    hits  = 0;
    for (int k = 1; k <= 50; k++) begin
      if (k == 10) begin
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd7;
        bus.ctrl_DIV      = 1'b1;
      end
      @(posedge clock);
      #1;
      if (k == 10) begin
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
      end
      if (bus.data_resultRDY) begin
        hits++;
        if (first == 0) first = k;
      end
    end
    check("abort strobe_edge", 64'(first), 64'd43);
    check("abort strobe_count", 64'(hits), 64'd1);
    check("abort result", 64'(bus.data_result), 64'd14);
    check("abort exception", 64'(bus.data_exception), 64'd0);

    // Reset asserted at E5 of a running multiply
    @(negedge clock);
    bus.data_operandA = 32'h0001_0000;
    bus.data_operandB = 32'h0000_0005;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    for (int k = 1; k <= 5; k++) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("midreset result", 64'(bus.data_result), 64'd0);
    check("midreset exception", 64'(bus.data_exception), 64'd0);
    check("midreset ready", 64'(bus.data_resultRDY), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    hits  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) hits++;
    end
    check("midreset no_strobe", 64'(hits), 64'd0);
    check("midreset result_after", 64'(bus.data_result), 64'd0);

    run_op("recover div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
